// File: rtl/key_debounce_latch.sv
// Push-button conditioner for four active-low, bouncy keys: synchronise, debounce,
// detect presses and latch the most recent press as a one-hot code with a strobe.
module key_debounce_latch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  input  logic       clear,
  output logic [3:0] key_held,
  output logic [3:0] key_onehot,
  output logic       key_press
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Synchroniser keeps raw pin polarity so its reset value of 1 means "released".
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic [3:0] pressed;

  logic [3:0][CNT_WIDTH-1:0] cnt_q;
  logic [3:0][CNT_WIDTH-1:0] cnt_d;
  logic [3:0]                held_q;
  logic [3:0]                held_d;
  logic [3:0]                held_dly_q;
  logic [3:0]                press_evt;

  logic [3:0] onehot_q;
  logic [3:0] onehot_d;
  logic       press_q;
  logic       press_d;

  assign pressed = ~sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= key_n;
      sync_q <= meta_q;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    held_d = held_q;
    for (int i = 0; i < 4; i++) begin
      if (pressed[i] == held_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        held_d[i] = ~held_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      held_q     <= 4'h0;
      held_dly_q <= 4'h0;
    end else begin
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      held_dly_q <= held_q;
    end
  end

  // Rising edges of the debounced level; releases never reach the latch.
  assign press_evt = held_q & ~held_dly_q;

  always_comb begin
    onehot_d = onehot_q;
    press_d  = 1'b0;
    if (press_evt != 4'h0) begin
      press_d = 1'b1;
      if (press_evt[0])      onehot_d = 4'b0001;
      else if (press_evt[1]) onehot_d = 4'b0010;
      else if (press_evt[2]) onehot_d = 4'b0100;
      else                   onehot_d = 4'b1000;
    end else if (clear) begin
      onehot_d = 4'h0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      onehot_q <= 4'h0;
      press_q  <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      press_q  <= press_d;
    end
  end

  assign key_held   = held_q;
  assign key_onehot = onehot_q;
  assign key_press  = press_q;

endmodule
